piece_lock_writer: RTL and testbench

- Upstream neighbour of Line_Clearer.
- When the active tetromino lands, this block writes the piece's four cells into board memory. It then hands the memory to Line_Clearer by holding its en high until cleared returns, and finally reports completion to the game controller.
- Board memory: one byte per cell, addr = row*BOARD_W + col. Row 0 is the top row. A nonzero byte means the cell is occupied.

---
 rtl/piece_lock_writer.sv | 159 +++++++++++++++
 tb/tb_piece_lock_writer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/piece_lock_writer.sv
// piece_lock_writer
// Writes a landed tetromino's cells into board memory. It then hands the
// board to the line clearer and reports completion with a one-cycle pulse.
//
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   lock           piece-landed request (accepted only while idle)
//   piece_x/_y     anchor column/row of the 4x4 shape window
//   shape          4x4 bitmap; bit i -> window row i[3:2], column i[1:0]
//   color          cell value; 0 is written as 1 so cells read as occupied
//   clr_done       line clearer "cleared"
//   clr_en         line clearer "en", held until clr_done is seen
//   we/addr/data_out  board memory write port (addr = row*10 + col)
//   mem_sel        memory mux select, high while scanning the shape
//   busy           high whenever not idle
//   done           one-cycle completion pulse
//   oob_err        sticky: a set shape bit landed off the board
//   top_out        sticky: a cell was written in the spawn rows
module piece_lock_writer #(
   parameter int BOARD_W  = 10,
   parameter int BOARD_H  = 20,
   parameter int TOP_ROWS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lock,
   input  logic [3:0]  piece_x,
   input  logic [4:0]  piece_y,
   input  logic [15:0] shape,
   input  logic [7:0]  color,
   input  logic        clr_done,
   output logic        clr_en,
   output logic        we,
   output logic [7:0]  addr,
   output logic [7:0]  data_out,
   output logic        mem_sel,
   output logic        busy,
   output logic        done,
   output logic        oob_err,
   output logic        top_out
);

   localparam logic [5:0] BOARD_W6  = 6'(BOARD_W);
   localparam logic [5:0] BOARD_H6  = 6'(BOARD_H);
   localparam logic [5:0] TOP_ROWS6 = 6'(TOP_ROWS);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_CLEAR, ST_DONE} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  idx_reg, idx_next;
   logic [3:0]  x_reg;
   logic [4:0]  y_reg;
   logic [15:0] shape_reg;
   logic [7:0]  color_reg;
   logic        clr_armed_reg;
   logic        oob_reg;
   logic        top_reg;

   // Current cell under the scan index. Six bits hold the largest sums
   // (31+3 rows, 15+3 columns) without wrapping back onto the board.
   logic [5:0] row;
   logic [5:0] col;
   logic       cell_set;
   logic       in_bounds;
   logic       cell_write;
   logic [7:0] cell_addr;

   assign row        = {1'b0, y_reg} + {4'b0000, idx_reg[3:2]};
   assign col        = {2'b00, x_reg} + {4'b0000, idx_reg[1:0]};
   assign cell_set   = shape_reg[idx_reg];
   assign in_bounds  = (col < BOARD_W6) && (row < BOARD_H6);
   assign cell_write = (state_reg == ST_SCAN) && cell_set && in_bounds;
   assign cell_addr  = 8'({row, 3'b000}) + 8'({row, 1'b0}) + 8'(col);

   assign oob_err = oob_reg;
   assign top_out = top_reg;

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      clr_en     = 1'b0;
      we         = 1'b0;
      addr       = 8'd0;
      data_out   = 8'd0;
      mem_sel    = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (lock) begin
               state_next = ST_SCAN;
               idx_next   = 4'd0;
            end
         end
         ST_SCAN: begin
            mem_sel = 1'b1;
            if (cell_write) begin
               we       = 1'b1;
               addr     = cell_addr;
               data_out = color_reg;
            end
            idx_next = idx_reg + 4'd1;
            if (idx_reg == 4'd15) begin
               state_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            clr_en = 1'b1;
            // A cleared level left over from the previous pass is ignored
            // until the clearer has seen en for a full cycle.
            if (clr_armed_reg && clr_done) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= 4'd0;
         x_reg         <= 4'd0;
         y_reg         <= 5'd0;
         shape_reg     <= 16'd0;
         color_reg     <= 8'd0;
         clr_armed_reg <= 1'b0;
         oob_reg       <= 1'b0;
         top_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         clr_armed_reg <= (state_reg == ST_CLEAR);
         if (state_reg == ST_IDLE && lock) begin
            x_reg     <= piece_x;
            y_reg     <= piece_y;
            shape_reg <= shape;
            color_reg <= (color == 8'd0) ? 8'd1 : color;
            oob_reg   <= 1'b0;
            top_reg   <= 1'b0;
         end else begin
            if (state_reg == ST_SCAN && cell_set && !in_bounds) begin
               oob_reg <= 1'b1;
            end
            if (cell_write && row < TOP_ROWS6) begin
               top_reg <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_piece_lock_writer.sv
// Directed bench for piece_lock_writer. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_piece_lock_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        lock = 1'b0;
   logic [3:0]  piece_x = 4'd0;
   logic [4:0]  piece_y = 5'd0;
   logic [15:0] shape = 16'd0;
   logic [7:0]  color = 8'd0;
   logic        clr_done = 1'b0;
   logic        clr_en, we, mem_sel, busy, done, oob_err, top_out;
   logic [7:0]  addr, data_out;

   int vectors = 0;
   int errors  = 0;
   int writes;
   int clr_cnt;
   int done_cyc;
   logic [7:0] exp_addr [16];

   piece_lock_writer dut (
      .clk(clk), .rst(rst), .lock(lock), .piece_x(piece_x), .piece_y(piece_y),
      .shape(shape), .color(color), .clr_done(clr_done), .clr_en(clr_en),
      .we(we), .addr(addr), .data_out(data_out), .mem_sel(mem_sel),
      .busy(busy), .done(done), .oob_err(oob_err), .top_out(top_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Walks the 16 scan cycles. The lock that started the scan is dropped
   // at the first one; lock_k selects a scan cycle where lock is pulsed again.
   task automatic scan(input string tag, input logic [15:0] mask, input logic [7:0] dat,
                       input int lock_k, output int nw);
      nw = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk($sformatf("%s_i%0d_ctl", tag, k), {28'd0, busy, mem_sel, clr_en, done}, 32'b1100);
         chk($sformatf("%s_i%0d_we", tag, k), {31'd0, we}, {31'd0, mask[k]});
         if (mask[k]) begin
            chk($sformatf("%s_i%0d_addr", tag, k), {24'd0, addr}, {24'd0, exp_addr[k]});
            chk($sformatf("%s_i%0d_data", tag, k), {24'd0, data_out}, {24'd0, dat});
         end
         if (we === 1'b1) nw++;
         lock = (k == lock_k);
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outs", {9'd0, clr_en, we, addr, data_out, mem_sel, busy, done, oob_err, top_out}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {9'd0, clr_en, we, addr, data_out, mem_sel, busy, done, oob_err, top_out}, 32'd0);

      // O-piece, clean landing
      piece_x = 4'd4; piece_y = 5'd18; shape = 16'h0033; color = 8'd5; lock = 1'b1;
      exp_addr[0] = 8'd184; exp_addr[1] = 8'd185; exp_addr[4] = 8'd194; exp_addr[5] = 8'd195;
      scan("t1", 16'h0033, 8'd5, -1, writes);
      chk("t1_writes", writes, 4);
      @(negedge clk);  // cycle 17
      chk("t1_c17", {27'd0, clr_en, mem_sel, we, busy, done}, 32'b10010);
      @(negedge clk);
      chk("t1_c18", {30'd0, clr_en, done}, 32'b10);
      @(negedge clk);
      chk("t1_c19", {30'd0, clr_en, done}, 32'b10);
      clr_done = 1'b1;
      @(negedge clk);
      chk("t1_done", {29'd0, clr_en, done, busy}, 32'b011);
      chk("t1_flags", {30'd0, oob_err, top_out}, 32'd0);
      clr_done = 1'b0;
      @(negedge clk);
      chk("t1_idle", {30'd0, done, busy}, 32'd0);

      // Right and bottom edges, locked in the first idle cycle after done
      piece_x = 4'd9; piece_y = 5'd19; shape = 16'h0013; color = 8'h07; lock = 1'b1;
      exp_addr[0] = 8'd199;
      scan("t2", 16'h0001, 8'h07, -1, writes);
      chk("t2_writes", writes, 1);
      @(negedge clk);  // cycle 17
      chk("t2_c17", {29'd0, clr_en, oob_err, top_out}, 32'b110);
      clr_done = 1'b1;
      @(negedge clk);
      chk("t2_c18", {30'd0, clr_en, done}, 32'b10);
      @(negedge clk);
      chk("t2_done", {29'd0, clr_en, done, oob_err}, 32'b011);
      clr_done = 1'b0;
      @(negedge clk);
      chk("t2_idle", {29'd0, busy, done, oob_err}, 32'b001);

      // Spawn zone, zero colour, stale clr_done, lock pulsed mid-scan
      clr_done = 1'b1;
      piece_x = 4'd3; piece_y = 5'd0; shape = 16'h000F; color = 8'd0; lock = 1'b1;
      exp_addr[0] = 8'd3; exp_addr[1] = 8'd4; exp_addr[2] = 8'd5; exp_addr[3] = 8'd6;
      scan("t3", 16'h000F, 8'd1, 5, writes);
      chk("t3_writes", writes, 4);
      clr_cnt = 0;
      done_cyc = -1;
      for (int c = 0; c < 8 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 0) chk("t3_c17_flags", {30'd0, oob_err, top_out}, 32'b01);
         if (clr_en === 1'b1) clr_cnt++;
         if (done === 1'b1) done_cyc = c;
      end
      chk("t3_clr_en_cycles", clr_cnt, 2);
      chk("t3_done_cycle", done_cyc, 2);
      clr_done = 1'b0;
      @(negedge clk);
      chk("t3_idle", {30'd0, busy, top_out}, 32'b01);

      // Reset in the middle of an O-piece scan
      piece_x = 4'd4; piece_y = 5'd18; shape = 16'h0033; color = 8'd5; lock = 1'b1;
      @(negedge clk);  // i=0
      lock = 1'b0;
      chk("t4_i0", {22'd0, top_out, we, addr}, {22'd0, 1'b0, 1'b1, 8'd184});
      @(negedge clk);  // i=1
      chk("t4_i1", {23'd0, we, addr}, {23'd0, 1'b1, 8'd185});
      @(negedge clk);  // i=2
      rst = 1'b0;
      #1;
      chk("t4_reset_now", {9'd0, clr_en, we, addr, data_out, mem_sel, busy, done, oob_err, top_out}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("t4_held%0d", c), {9'd0, clr_en, we, addr, data_out, mem_sel, busy, done, oob_err, top_out}, 32'd0);
      end
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("t4_post%0d", c), {28'd0, busy, we, mem_sel, clr_en}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
      $fatal(1, "timeout");
   end

endmodule
